// File: rtl/bp_be_cmd_queue_gen_if.sv
// Enqueue/dequeue handshake bundle between the FE command producer and the BE command consumer.
interface bp_be_cmd_queue_gen_if #(
    parameter int width_p = 64
);
    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;

    modport master (output v_i, data_i, yumi_i, input ready_o, v_o, data_o);
    modport slave  (input v_i, data_i, yumi_i, output ready_o, v_o, data_o);
endinterface

// File: rtl/bp_be_cmd_queue_gen.sv
// Generic-depth BE command FIFO with flush, occupancy/almost-full reporting, sticky overflow
// and an optional same-cycle bypass when empty.
module bp_be_cmd_queue_gen #(
    parameter int width_p              = 64,
    parameter int els_p                = 8,
    parameter int almost_full_thresh_p = els_p - 2,
    parameter bit bypass_p             = 1'b0,
    localparam int ptr_w_lp            = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cnt_w_lp            = $clog2(els_p + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    bp_be_cmd_queue_gen_if.slave  cmd_if,
    input  logic                  flush_i,
    output logic [cnt_w_lp-1:0]   count_o,
    output logic                  almost_full_o,
    output logic                  empty_r_o,
    output logic                  empty_n_o,
    output logic                  full_r_o,
    output logic                  full_n_o,
    output logic                  overflow_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d;
    logic [ptr_w_lp-1:0] wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                empty_q, full_q, afull_q, ovf_q;
    logic                empty_d, full_d, afull_d, ovf_d;

    logic                ready_s, v_s, enq_s, deq_s;
    logic                bypass_take_s, write_s, pop_s;
    logic [width_p-1:0]  data_s;

    // Wrap at els_p-1 by explicit compare so any depth works.
    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] ptr);
        if (ptr == ptr_w_lp'(els_p - 1)) begin
            ptr_inc = '0;
        end else begin
            ptr_inc = ptr + ptr_w_lp'(1);
        end
    endfunction

    // Handshake, head selection and next-state computation.
    always_comb begin
        ready_s = reset_n_i & ~full_q;
        if (bypass_p) begin
            v_s = reset_n_i & (~empty_q | cmd_if.v_i);
        end else begin
            v_s = reset_n_i & ~empty_q;
        end
        if (bypass_p && empty_q) begin
            data_s = cmd_if.data_i;
        end else begin
            data_s = mem_q[rptr_q];
        end

        enq_s = cmd_if.v_i & ready_s;
        deq_s = cmd_if.yumi_i & v_s;
        // An empty bypass queue that is consumed in the same cycle never touches storage.
        bypass_take_s = bypass_p & empty_q & enq_s & deq_s;
        write_s       = enq_s & ~bypass_take_s & ~flush_i;
        pop_s         = deq_s & ~bypass_take_s & ~flush_i;

        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        if (flush_i) begin
            rptr_d  = '0;
            wptr_d  = '0;
            count_d = '0;
        end else begin
            if (write_s) begin
                wptr_d = ptr_inc(wptr_q);
            end else begin
                wptr_d = wptr_q;
            end
            if (pop_s) begin
                rptr_d = ptr_inc(rptr_q);
            end else begin
                rptr_d = rptr_q;
            end
            count_d = count_q + cnt_w_lp'(write_s) - cnt_w_lp'(pop_s);
        end

        empty_d = (count_d == cnt_w_lp'(0));
        full_d  = (count_d == cnt_w_lp'(els_p));
        afull_d = (count_d >= cnt_w_lp'(almost_full_thresh_p));
        ovf_d   = ovf_q | (cmd_if.v_i & ~ready_s);
    end

    // Payload storage; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (write_s) begin
            mem_q[wptr_q] <= cmd_if.data_i;
        end
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign cmd_if.ready_o = ready_s;
    assign cmd_if.v_o     = v_s;
    assign cmd_if.data_o  = data_s;
    assign count_o        = count_q;
    assign almost_full_o  = afull_q;
    assign empty_r_o      = empty_q;
    assign full_r_o       = full_q;
    assign empty_n_o      = empty_d;
    assign full_n_o       = full_d;
    assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_bp_be_cmd_queue_gen.sv
// Drives two queue configurations (5 deep plain, 8 deep bypass) against a queue-based reference model.
module tb_bp_be_cmd_queue_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bp_be_cmd_queue_gen_if #(.width_p(16)) if5 ();
    bp_be_cmd_queue_gen_if #(.width_p(16)) if8 ();

    logic       flush5, flush8;
    logic [2:0] count5;
    logic [3:0] count8;
    logic af5, er5, en5, fr5, fn5, ovf5;
    logic af8, er8, en8, fr8, fn8, ovf8;

    bp_be_cmd_queue_gen #(.width_p(16), .els_p(5), .bypass_p(1'b0)) u_q5 (
        .clk_i(clk), .reset_n_i(rst_n), .cmd_if(if5), .flush_i(flush5),
        .count_o(count5), .almost_full_o(af5), .empty_r_o(er5), .empty_n_o(en5),
        .full_r_o(fr5), .full_n_o(fn5), .overflow_o(ovf5)
    );

    bp_be_cmd_queue_gen #(.width_p(16), .els_p(8), .bypass_p(1'b1)) u_q8 (
        .clk_i(clk), .reset_n_i(rst_n), .cmd_if(if8), .flush_i(flush8),
        .count_o(count8), .almost_full_o(af8), .empty_r_o(er8), .empty_n_o(en8),
        .full_r_o(fr8), .full_n_o(fn8), .overflow_o(ovf8)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cur_inst = 0;

    logic [15:0] mq [2][$];
    bit          movf [2];

    logic        o_ready, o_v, o_af, o_er, o_en, o_fr, o_fn, o_ovf;
    logic [15:0] o_data;
    logic [31:0] o_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s q%0d @%0t: got %0h expected %0h", tag, cur_inst, $time, obs, exp);
        end
    endtask

    task automatic sample(input int inst);
        if (inst == 0) begin
            o_ready = if5.ready_o; o_v = if5.v_o; o_data = if5.data_o; o_count = 32'(count5);
            o_af = af5; o_er = er5; o_en = en5; o_fr = fr5; o_fn = fn5; o_ovf = ovf5;
        end else begin
            o_ready = if8.ready_o; o_v = if8.v_o; o_data = if8.data_o; o_count = 32'(count8);
            o_af = af8; o_er = er8; o_en = en8; o_fr = fr8; o_fn = fn8; o_ovf = ovf8;
        end
    endtask

    task automatic set_in(input int inst, input bit v, input logic [15:0] d, input bit y, input bit f);
        if5.v_i = 1'b0; if5.data_i = 16'h0; if5.yumi_i = 1'b0; flush5 = 1'b0;
        if8.v_i = 1'b0; if8.data_i = 16'h0; if8.yumi_i = 1'b0; flush8 = 1'b0;
        if (inst == 0) begin
            if5.v_i = v; if5.data_i = d; if5.yumi_i = y; flush5 = f;
        end else begin
            if8.v_i = v; if8.data_i = d; if8.yumi_i = y; flush8 = f;
        end
    endtask

    // One clock of stimulus on one queue, checked against the reference model.
    task automatic cycle(input int inst, input bit v, input logic [15:0] d, input bit y, input bit f);
        int cnt, els, thr, nxt;
        bit byp_en, rdy, ev, enq, deq, byp;
        logic [15:0] ed;
        @(negedge clk);
        set_in(inst, v, d, y, f);
        #1;
        cur_inst = inst;
        sample(inst);
        els    = (inst == 0) ? 5 : 8;
        thr    = els - 2;
        byp_en = (inst == 1);
        cnt    = mq[inst].size();
        rdy    = (cnt != els);
        if (cnt == 0) begin
            ev = byp_en & v;
            ed = d;
        end else begin
            ev = 1'b1;
            ed = mq[inst][0];
        end
        enq = v & rdy;
        deq = y & ev;
        byp = (cnt == 0) & deq;
        nxt = f ? 0 : cnt + int'(enq) - int'(deq);
        chk("ready", 32'(o_ready), 32'(rdy));
        chk("v_o", 32'(o_v), 32'(ev));
        if (ev) chk("data_o", 32'(o_data), 32'(ed));
        chk("count", o_count, 32'(cnt));
        chk("empty_r", 32'(o_er), 32'(cnt == 0));
        chk("full_r", 32'(o_fr), 32'(cnt == els));
        chk("almost_full", 32'(o_af), 32'(cnt >= thr));
        chk("empty_n", 32'(o_en), 32'(nxt == 0));
        chk("full_n", 32'(o_fn), 32'(nxt == els));
        chk("overflow", 32'(o_ovf), 32'(movf[inst]));
        @(posedge clk);
        #1;
        if (v && !rdy) movf[inst] = 1'b1;
        if (f) begin
            mq[inst].delete();
        end else begin
            if (deq && !byp) void'(mq[inst].pop_front());
            if (enq && !byp) mq[inst].push_back(d);
        end
    endtask

    task automatic chk_in_reset();
        for (int k = 0; k < 2; k++) begin
            cur_inst = k;
            sample(k);
            chk("rst_v_o", 32'(o_v), 32'd0);
            chk("rst_ready", 32'(o_ready), 32'd0);
            chk("rst_count", o_count, 32'd0);
            chk("rst_empty_r", 32'(o_er), 32'd1);
            chk("rst_empty_n", 32'(o_en), 32'd1);
            chk("rst_full_r", 32'(o_fr), 32'd0);
            chk("rst_full_n", 32'(o_fn), 32'd0);
            chk("rst_afull", 32'(o_af), 32'd0);
            chk("rst_ovf", 32'(o_ovf), 32'd0);
        end
    endtask

    task automatic clear_model();
        mq[0].delete();
        mq[1].delete();
        movf[0] = 1'b0;
        movf[1] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 1'b0, 16'h0, 1'b0, 1'b0);
        if5.v_i = 1'b1; if8.v_i = 1'b1; if8.data_i = 16'h1234;
        clear_model();
        #7;
        chk_in_reset();
        @(negedge clk);
        set_in(0, 1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        cycle(0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Fill the 5-deep queue, then drain it in order.
        for (int i = 1; i <= 5; i++) cycle(0, 1'b1, 16'(16'hA0 + i), 1'b0, 1'b0);
        cycle(0, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(0, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Sustained enqueue+dequeue at occupancy 2 across several wraps.
        cycle(0, 1'b1, 16'h0B01, 1'b0, 1'b0);
        cycle(0, 1'b1, 16'h0B02, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(0, 1'b1, 16'($urandom), 1'b1, 1'b0);
        cycle(0, 1'b0, 16'h0, 1'b0, 1'b0);

        // Full 8-deep queue: overflow, full enq+deq, flush keeps overflow sticky.
        for (int i = 0; i < 8; i++) cycle(1, 1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(1, 1'b1, 16'hDEAD, 1'b0, 1'b0);
        cycle(1, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1, 1'b1, 16'hC0DE, 1'b1, 1'b0);
        cycle(1, 1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1, 1'b0, 16'h0, 1'b0, 1'b0);

        // Flush beats simultaneous enqueue and dequeue.
        for (int i = 0; i < 3; i++) cycle(0, 1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(0, 1'b1, 16'h9999, 1'b1, 1'b1);
        cycle(0, 1'b1, 16'h0055, 1'b0, 1'b0);
        cycle(0, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(0, 1'b0, 16'h0, 1'b1, 1'b0);

        // Bypass on the empty 8-deep queue.
        cycle(1, 1'b1, 16'h0077, 1'b1, 1'b0);
        cycle(1, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1, 1'b1, 16'h0077, 1'b0, 1'b0);
        cycle(1, 1'b0, 16'h0, 1'b0, 1'b0);
        cycle(1, 1'b0, 16'h0, 1'b1, 1'b0);

        // Randomized traffic on both configurations.
        for (int i = 0; i < 800; i++) begin
            cycle(int'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0), 16'($urandom),
                  ($urandom_range(2, 0) != 0), ($urandom_range(31, 0) == 0));
        end

        // Asynchronous reset mid-stream with four entries held.
        cycle(0, 1'b0, 16'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(0, 1'b1, 16'($urandom), 1'b0, 1'b0);
        cycle(0, 1'b0, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        if5.v_i = 1'b1; if8.v_i = 1'b1; if8.data_i = 16'h4321;
        #1;
        chk_in_reset();
        @(posedge clk);
        #1;
        chk_in_reset();
        @(negedge clk);
        set_in(0, 1'b0, 16'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        clear_model();
        cycle(0, 1'b1, 16'h003C, 1'b0, 1'b0);
        cycle(0, 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(0, 1'b0, 16'h0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
